csr_access_ctrl: RTL and testbench
==================================

CSR_ACCESS_CTRL -- requirements
Module: csr_access_ctrl

Interface
REQ-001 Parameter MSTATUS_WMASK, default 32'h0000_1888, writable-bit mask for mstatus (MIE, MPIE, MPP).
REQ-002 Parameter MISA_WRITABLE, default 0, when 0 misa writes are accepted and discarded (WARL).
REQ-003 CLK  in  1  single clock; all state updates on rising edge.
REQ-004 RST  in  1  reset, synchronous, active-high.
REQ-005 req_valid  in  1  CSR instruction request present.
REQ-006 req_ready  out  1  controller can accept a request.
REQ-007 req_op  in  2  01=RW, 10=RS (set), 11=RC (clear), 00=reserved.
REQ-008 req_addr  in  12  CSR address.
REQ-009 req_wdata  in  32  source operand (rs1 value or zero-extended uimm).
REQ-010 req_src_zero  in  1  source register is x0 or uimm==0.
REQ-011 req_priv  in  2  current privilege: 11=M, 01=S, 00=U.
REQ-012 csr_sel  out  6  one-hot bank select: [0]mstatus 0x300, [1]misa 0x301, [2]mvendorid 0xF11, [3]marchid 0xF12, [4]mimpid 0xF13, [5]mhartid 0xF14.
REQ-013 csr_rdata  in  32  read data from the selected CSR bank, valid the same cycle csr_sel is asserted.
REQ-014 csr_we  out  1  single-cycle write enable to the selected CSR (drives that register's EN).
REQ-015 csr_wdata  out  32  value written when csr_we=1.
REQ-016 rsp_valid  out  1  response available.
REQ-017 rsp_ready  in  1  consumer accepts response.
REQ-018 rsp_rdata  out  32  old CSR value (zero when illegal).
REQ-019 rsp_illegal  out  1  illegal-instruction exception flag.

Function
REQ-020 FSM states IDLE, READ, WRITE, RESP; req_ready=1 only in IDLE.
REQ-021 Request accepted when req_valid&req_ready; req_op, req_addr, req_wdata, req_src_zero and req_priv are captured on acceptance and held until return to IDLE.
REQ-022 Illegal when any of: addr not in REQ-012 table; req_op==00; req_priv < addr[9:8]; addr[11:10]==11 with write intent.
REQ-023 Write intent = (op==RW) or (op in {RS,RC} and req_src_zero==0).
REQ-024 IDLE -> READ on legal accept; IDLE -> RESP on illegal accept, with rsp_illegal=1, rsp_rdata=0, no csr_sel or csr_we asserted.
REQ-025 READ: csr_sel asserted for exactly one cycle; csr_rdata captured as old value; next state WRITE.
REQ-026 WRITE: new = RW: wdata; RS: old|wdata; RC: old&~wdata; csr_sel held one cycle; csr_we=1 only if write intent and target writable; next state RESP.
REQ-027 mstatus write: csr_wdata = (old & ~MSTATUS_WMASK) | (new & MSTATUS_WMASK).
REQ-028 misa with MISA_WRITABLE=0: csr_we=0, rsp_illegal=0 (WARL, no exception).
REQ-029 csr_sel=0 and csr_we=0 in IDLE and RESP.
REQ-030 RESP: rsp_valid=1, rsp_rdata=captured old value; rsp_rdata and rsp_illegal stable while rsp_valid&!rsp_ready; exit to IDLE on rsp_ready.
REQ-031 Legal latency: accept at cycle T, csr_sel at T+1 and T+2, csr_we at T+2, rsp_valid from T+3; illegal: rsp_valid from T+1.
REQ-032 req_valid ignored outside IDLE; no queueing; back-to-back request accepted no earlier than the cycle after response handshake.

Reset
REQ-033 While RST=1: state=IDLE, req_ready=0, rsp_valid=0, rsp_illegal=0, rsp_rdata=0, csr_sel=0, csr_we=0, captured registers cleared.
REQ-034 RST asserted mid-operation (READ/WRITE/RESP) aborts the access next edge; no csr_we issued after the reset edge; pending response discarded.
REQ-035 req_ready=1 on first cycle after RST deasserts.

Verification
REQ-036 M-mode RS mstatus, old=0, wdata=0x8, src_zero=0 -> csr_we at T+2, csr_wdata=0x8, rsp_rdata=0, rsp_illegal=0, rsp_valid at T+3.
REQ-037 M-mode RW mstatus wdata=0xFFFF_FFFF, old=0 -> csr_wdata=0x0000_1888.
REQ-038 M-mode RS mhartid (0xF14) src_zero=1 -> legal, rsp_rdata=csr_rdata, csr_we never asserted; same with RW -> rsp_illegal=1 at T+1, rsp_rdata=0.
REQ-039 U-mode (priv=00) RW to 0x300 and any access to 0x7C0 -> rsp_illegal=1, csr_sel never asserted.
REQ-040 M-mode RW misa wdata=0 -> rsp_rdata=old misa, csr_we=0, rsp_illegal=0.
REQ-041 rsp_ready held low 5 cycles, RST pulsed during WRITE of a second access -> response stable until handshake; after reset no csr_we, rsp_valid=0, req_ready=1.

Source files
------------

// File: rtl/csr_access_ctrl.sv
// CSR instruction access controller: legality check, read-modify-write sequencing
// over a one-hot CSR bank select, and a held response until the consumer accepts it.
module csr_access_ctrl #(
  parameter logic [31:0] MSTATUS_WMASK = 32'h0000_1888,
  parameter int          MISA_WRITABLE = 0
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [11:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic        req_src_zero,
  input  logic [1:0]  req_priv,
  output logic [5:0]  csr_sel,
  input  logic [31:0] csr_rdata,
  output logic        csr_we,
  output logic [31:0] csr_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_illegal
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  localparam logic [1:0] OP_RW = 2'b01;
  localparam logic [1:0] OP_RS = 2'b10;
  localparam logic [1:0] OP_RC = 2'b11;

  // Bank select bit gi decodes the address held in slice gi of this table.
  localparam logic [71:0] CSR_ADDRS = {12'hF14, 12'hF13, 12'hF12, 12'hF11, 12'h301, 12'h300};

  state_t      state_reg, state_next;
  logic [1:0]  op_reg;
  logic [11:0] addr_reg;
  logic [31:0] wdata_reg;
  logic        src_zero_reg;
  logic        illegal_reg;
  logic [31:0] old_reg;

  logic [5:0]  sel_in;
  logic [5:0]  sel_cur;
  logic        wr_intent_in;
  logic        illegal_in;
  logic        wr_intent_cur;
  logic        writable_cur;
  logic [31:0] new_val;
  logic [31:0] write_val;

  genvar gi;
  generate
    for (gi = 0; gi < 6; gi++) begin : g_dec
      assign sel_in[gi]  = (req_addr == CSR_ADDRS[gi*12 +: 12]);
      assign sel_cur[gi] = (addr_reg == CSR_ADDRS[gi*12 +: 12]);
    end
  endgenerate

  // Legality is resolved at acceptance so an illegal access can answer one cycle later.
  assign wr_intent_in = (req_op == OP_RW) ||
                        (((req_op == OP_RS) || (req_op == OP_RC)) && !req_src_zero);
  assign illegal_in   = (sel_in == 6'b0) || (req_op == 2'b00) ||
                        (req_priv < req_addr[9:8]) ||
                        ((req_addr[11:10] == 2'b11) && wr_intent_in);

  assign wr_intent_cur = (op_reg == OP_RW) ||
                         (((op_reg == OP_RS) || (op_reg == OP_RC)) && !src_zero_reg);
  assign writable_cur  = sel_cur[0] || (sel_cur[1] && (MISA_WRITABLE != 0));

  always_comb begin
    new_val = wdata_reg;
    case (op_reg)
      OP_RS:   new_val = old_reg | wdata_reg;
      OP_RC:   new_val = old_reg & ~wdata_reg;
      default: new_val = wdata_reg;
    endcase
  end

  // mstatus keeps its read-only fields from the old value.
  assign write_val = sel_cur[0] ? ((old_reg & ~MSTATUS_WMASK) | (new_val & MSTATUS_WMASK))
                                : new_val;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      op_reg       <= 2'b00;
      addr_reg     <= 12'h000;
      wdata_reg    <= 32'h0;
      src_zero_reg <= 1'b0;
      illegal_reg  <= 1'b0;
      old_reg      <= 32'h0;
    end else if ((state_reg == IDLE) && req_valid) begin
      op_reg       <= req_op;
      addr_reg     <= req_addr;
      wdata_reg    <= req_wdata;
      src_zero_reg <= req_src_zero;
      illegal_reg  <= illegal_in;
      old_reg      <= 32'h0;
    end else if (state_reg == READ) begin
      old_reg <= csr_rdata;
    end
  end

  always_comb begin
    state_next  = state_reg;
    req_ready   = 1'b0;
    csr_sel     = 6'b0;
    csr_we      = 1'b0;
    csr_wdata   = 32'h0;
    rsp_valid   = 1'b0;
    rsp_rdata   = 32'h0;
    rsp_illegal = 1'b0;
    case (state_reg)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_next = illegal_in ? RESP : READ;
      end
      READ: begin
        csr_sel    = sel_cur;
        state_next = WRITE;
      end
      WRITE: begin
        csr_sel    = sel_cur;
        csr_we     = wr_intent_cur && writable_cur;
        csr_wdata  = csr_we ? write_val : 32'h0;
        state_next = RESP;
      end
      RESP: begin
        rsp_valid   = 1'b1;
        rsp_rdata   = old_reg;
        rsp_illegal = illegal_reg;
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    // Reset silences every output immediately, including a write already on the bus.
    if (RST) begin
      state_next  = IDLE;
      req_ready   = 1'b0;
      csr_sel     = 6'b0;
      csr_we      = 1'b0;
      csr_wdata   = 32'h0;
      rsp_valid   = 1'b0;
      rsp_rdata   = 32'h0;
      rsp_illegal = 1'b0;
    end
  end

endmodule

// File: tb/tb_csr_access_ctrl.sv
// Testbench for csr_access_ctrl: directed and random CSR accesses against a
// behavioural CSR bank model, with latency, select, write and response checks.
module tb_csr_access_ctrl;

  localparam logic [31:0] WMASK  = 32'h0000_1888;
  localparam int          MISA_W = 0;

  logic        CLK = 1'b0;
  logic        RST;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [11:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_src_zero;
  logic [1:0]  req_priv;
  logic [5:0]  csr_sel;
  logic [31:0] csr_rdata;
  logic        csr_we;
  logic [31:0] csr_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_illegal;

  int checks = 0;
  int errors = 0;

  logic [11:0] addr_tab   [6] = '{12'h300, 12'h301, 12'hF11, 12'hF12, 12'hF13, 12'hF14};
  logic [31:0] env_bank   [6] = '{32'h0, 32'h4014_1101, 32'h0000_0612, 32'h8000_0019, 32'h2024_0101, 32'h0000_0003};
  logic [31:0] model_bank [6] = '{32'h0, 32'h4014_1101, 32'h0000_0612, 32'h8000_0019, 32'h2024_0101, 32'h0000_0003};

  always #5 CLK = ~CLK;

  csr_access_ctrl #(.MSTATUS_WMASK(WMASK), .MISA_WRITABLE(MISA_W)) dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_src_zero(req_src_zero), .req_priv(req_priv),
    .csr_sel(csr_sel), .csr_rdata(csr_rdata), .csr_we(csr_we), .csr_wdata(csr_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_illegal(rsp_illegal)
  );

  // CSR bank seen by the controller: combinational read, write on csr_we.
  always_comb begin
    csr_rdata = 32'h0;
    for (int i = 0; i < 6; i++) if (csr_sel[i]) csr_rdata = env_bank[i];
  end

  always @(posedge CLK) begin
    if (!RST && csr_we) begin
      for (int i = 0; i < 6; i++) if (csr_sel[i]) env_bank[i] <= csr_wdata;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wdata,
                       input logic sz, input logic [1:0] priv,
                       output bit ill, output int idx, output logic [31:0] old,
                       output bit we, output logic [31:0] wval);
    bit          wi;
    logic [31:0] newv;
    idx = -1;
    for (int i = 0; i < 6; i++) if (addr == addr_tab[i]) idx = i;
    wi  = (op == 2'b01) || ((op != 2'b00) && !sz);
    ill = (idx < 0) || (op == 2'b00) || (priv < addr[9:8]) || ((addr[11:10] == 2'b11) && wi);
    old = 32'h0;
    if (!ill) old = model_bank[idx];
    case (op)
      2'b01:   newv = wdata;
      2'b10:   newv = old | wdata;
      2'b11:   newv = old & ~wdata;
      default: newv = 32'h0;
    endcase
    we   = !ill && wi && ((idx == 0) || ((idx == 1) && (MISA_W != 0)));
    wval = (idx == 0) ? ((old & ~WMASK) | (newv & WMASK)) : newv;
  endtask

  task automatic cmp_banks(input string name);
    for (int i = 0; i < 6; i++) chk({name, ".bank"}, env_bank[i], model_bank[i]);
  endtask

  task automatic do_access(input string name, input logic [1:0] op, input logic [11:0] addr,
                           input logic [31:0] wdata, input logic sz, input logic [1:0] priv,
                           input int stall, input bit abort);
    bit          ill, we;
    int          idx, sel_n, we_n, we_k, rsp_k;
    bit          sel_bad;
    logic [31:0] old, wval, we_d;
    logic [5:0]  exp_sel;
    model(op, addr, wdata, sz, priv, ill, idx, old, we, wval);
    exp_sel = 6'b0;
    if (idx >= 0) exp_sel[idx] = 1'b1;

    @(negedge CLK);
    chk({name, ".ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wdata;
    req_src_zero = sz; req_priv = priv;
    @(posedge CLK);
    #1;
    // A legal mstatus write kept on the bus while busy must be ignored.
    req_op = 2'b01; req_addr = 12'h300; req_wdata = $urandom; req_src_zero = 1'b0; req_priv = 2'b11;
    if (abort) req_valid = 1'b0;

    sel_n = 0; we_n = 0; we_k = 0; rsp_k = 0; sel_bad = 1'b0; we_d = 32'h0;
    for (int k = 1; k <= 8 && rsp_k == 0; k++) begin
      @(negedge CLK);
      if (csr_sel != 6'b0) begin
        sel_n++;
        if (csr_sel !== exp_sel) sel_bad = 1'b1;
      end
      if (csr_we === 1'b1) begin we_n++; we_k = k; we_d = csr_wdata; end
      if (rsp_valid === 1'b1) rsp_k = k;
      else chk({name, ".busy_ready"}, 32'(req_ready), 32'd0);
      if (abort && k == 2) break;
    end

    if (abort) begin
      chk({name, ".abort_sel_cycles"}, 32'(sel_n), 32'd2);
      RST = 1'b1;
      #1;
      chk({name, ".rst_we"}, 32'(csr_we), 32'd0);
      chk({name, ".rst_sel"}, 32'(csr_sel), 32'd0);
      chk({name, ".rst_ready"}, 32'(req_ready), 32'd0);
      repeat (2) begin
        @(negedge CLK);
        chk({name, ".rst_we"}, 32'(csr_we), 32'd0);
        chk({name, ".rst_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({name, ".rst_rdata"}, rsp_rdata, 32'd0);
        chk({name, ".rst_ready"}, 32'(req_ready), 32'd0);
      end
      RST = 1'b0;
      #1;
      chk({name, ".post_rst_ready"}, 32'(req_ready), 32'd1);
      repeat (3) begin
        @(negedge CLK);
        chk({name, ".post_rst_we"}, 32'(csr_we), 32'd0);
        chk({name, ".post_rst_rsp_valid"}, 32'(rsp_valid), 32'd0);
      end
      cmp_banks(name);
      $display("access %s op=%0d addr=%03h priv=%0d aborted by reset", name, op, addr, priv);
      return;
    end

    chk({name, ".rsp_latency"}, 32'(rsp_k), ill ? 32'd1 : 32'd3);
    chk({name, ".sel_cycles"}, 32'(sel_n), ill ? 32'd0 : 32'd2);
    chk({name, ".sel_onehot"}, 32'(sel_bad), 32'd0);
    chk({name, ".we_count"}, 32'(we_n), we ? 32'd1 : 32'd0);
    if (we) begin
      chk({name, ".we_cycle"}, 32'(we_k), 32'd2);
      chk({name, ".wdata"}, we_d, wval);
    end
    chk({name, ".rdata"}, rsp_rdata, old);
    chk({name, ".illegal"}, 32'(rsp_illegal), 32'(ill));

    repeat (stall) begin
      @(negedge CLK);
      chk({name, ".hold_valid"}, 32'(rsp_valid), 32'd1);
      chk({name, ".hold_rdata"}, rsp_rdata, old);
      chk({name, ".hold_illegal"}, 32'(rsp_illegal), 32'(ill));
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge CLK);
    #1;
    rsp_ready = 1'b0;
    @(negedge CLK);
    chk({name, ".done_valid"}, 32'(rsp_valid), 32'd0);
    chk({name, ".done_ready"}, 32'(req_ready), 32'd1);
    if (we) model_bank[idx] = wval;
    cmp_banks(name);
    $display("access %s op=%0d addr=%03h priv=%0d wdata=%08h -> illegal=%0d rdata=%08h we=%0d",
             name, op, addr, priv, wdata, ill, old, we);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  r_op, r_priv;
    logic [11:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_sz;
    int          r_sel, r_p;

    RST = 1'b1; req_valid = 1'b0; req_op = 2'b00; req_addr = 12'h000; req_wdata = 32'h0;
    req_src_zero = 1'b0; req_priv = 2'b00; rsp_ready = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("reset.ready", 32'(req_ready), 32'd0);
    chk("reset.rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset.illegal", 32'(rsp_illegal), 32'd0);
    chk("reset.rdata", rsp_rdata, 32'd0);
    chk("reset.sel", 32'(csr_sel), 32'd0);
    chk("reset.we", 32'(csr_we), 32'd0);
    RST = 1'b0;
    #1;
    chk("reset.ready_after", 32'(req_ready), 32'd1);
    $display("reset released");

    do_access("rs_mstatus",     2'b10, 12'h300, 32'h0000_0008, 1'b0, 2'b11, 0, 1'b0);
    do_access("rc_mstatus",     2'b11, 12'h300, 32'hFFFF_FFFF, 1'b0, 2'b11, 1, 1'b0);
    do_access("rw_mstatus_all", 2'b01, 12'h300, 32'hFFFF_FFFF, 1'b0, 2'b11, 0, 1'b0);
    do_access("rs_mhartid_rd",  2'b10, 12'hF14, 32'h0,        1'b1, 2'b11, 0, 1'b0);
    do_access("rw_mhartid",     2'b01, 12'hF14, 32'h1234_5678, 1'b0, 2'b11, 2, 1'b0);
    do_access("u_rw_mstatus",   2'b01, 12'h300, 32'h0000_0008, 1'b0, 2'b00, 0, 1'b0);
    do_access("u_rs_7c0",       2'b10, 12'h7C0, 32'h0,        1'b1, 2'b00, 0, 1'b0);
    do_access("m_rw_7c0",       2'b01, 12'h7C0, 32'h5,        1'b0, 2'b11, 0, 1'b0);
    do_access("rw_misa",        2'b01, 12'h301, 32'h0,        1'b0, 2'b11, 0, 1'b0);
    do_access("op_reserved",    2'b00, 12'h300, 32'h8,        1'b0, 2'b11, 0, 1'b0);
    do_access("s_rs_misa",      2'b10, 12'h301, 32'h0,        1'b1, 2'b01, 0, 1'b0);
    do_access("stall5",         2'b10, 12'h300, 32'h0000_0080, 1'b0, 2'b11, 5, 1'b0);
    do_access("rst_in_write",   2'b01, 12'h300, 32'h0000_0000, 1'b0, 2'b11, 0, 1'b1);

    for (int n = 0; n < 40; n++) begin
      r_sel = $urandom_range(0, 7);
      if (r_sel < 6)       r_addr = addr_tab[r_sel];
      else if (r_sel == 6) r_addr = 12'h7C0;
      else                 r_addr = 12'($urandom);
      r_op = 2'($urandom);
      r_sz = 1'($urandom_range(0, 1));
      r_wdata = r_sz ? 32'h0 : $urandom;
      r_p = $urandom_range(0, 3);
      r_priv = (r_p == 0) ? 2'b00 : ((r_p == 1) ? 2'b01 : 2'b11);
      do_access("rnd", r_op, r_addr, r_wdata, r_sz, r_priv, $urandom_range(0, 3), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
